// File: rtl/msx_audio_pkg.sv
// msx_audio_pkg
//   Shared types and constants for the MSX audio mixer family.
//   - mute_state_t : mute/ramp FSM states
//   - ATT_MAX      : deepest attenuation step (arithmetic shift count)
//   - GAIN_UNITY   : gain code that passes a channel through unchanged
//   - GAIN_SHIFT   : gain is g / 2**GAIN_SHIFT
package msx_audio_pkg;

    typedef enum logic [1:0] {
        PLAY,
        RAMP_DOWN,
        MUTED,
        RAMP_UP
    } mute_state_t;

    localparam logic [3:0]  ATT_MAX    = 4'd15;
    localparam int unsigned GAIN_UNITY = 8;
    localparam int unsigned GAIN_SHIFT = 3;

endpackage

// File: rtl/msx_audio_sat.sv
// msx_audio_sat
//   Combinational signed saturation from IN_W bits down to OUT_W bits.
//   Ports:
//     din  in  IN_W  : signed wide value
//     dout out OUT_W : din clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
//     clip out 1     : 1 when clamping changed the value
module msx_audio_sat #(
    parameter int unsigned IN_W  = 23,
    parameter int unsigned OUT_W = 16
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout,
    output logic             clip
);

    localparam logic [OUT_W-1:0] S_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] S_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    generate
        if (IN_W > OUT_W) begin : g_narrow
            // The value fits when every bit from the output sign bit upward
            // is a copy of the input sign.
            logic [IN_W-OUT_W:0] top;

            always_comb begin
                top  = din[IN_W-1:OUT_W-1];
                dout = din[OUT_W-1:0];
                clip = 1'b0;
                if (!((&top) || !(|top))) begin
                    clip = 1'b1;
                    dout = din[IN_W-1] ? S_MIN : S_MAX;
                end
            end
        end else begin : g_wide
            always_comb begin
                dout = OUT_W'($signed(din));
                clip = 1'b0;
            end
        end
    endgenerate

endmodule

// File: rtl/msx_audio_mixer.sv
// msx_audio_mixer
//   Pipelined N-channel mixer: per-channel offset-binary conversion and gain
//   (S1), full-width sum (S2), saturation + mute attenuator (S3), plus a
//   stretched activity indicator.
//   Ports:
//     clk_sys     in  1                 : system clock
//     reset_n     in  1                 : asynchronous active-low reset
//     ce_sample   in  1                 : input sample strobe (any cycle)
//     ch_data     in  CHANNELS*IN_W     : channel k at [k*IN_W +: IN_W]
//     ch_unsigned in  CHANNELS          : 1 = channel k is offset-binary
//     ch_gain     in  CHANNELS*GAIN_W   : unsigned gain, g/8
//     mute        in  1                 : mute request level
//     audio_out   out OUT_W             : signed mixed sample, held
//     out_valid   out 1                 : pulse when audio_out updates
//     clip        out 1                 : pulse with out_valid on saturation
//     level_led   out 1                 : activity seen in last LED_HOLD clocks
module msx_audio_mixer
    import msx_audio_pkg::*;
#(
    parameter int unsigned CHANNELS   = 3,
    parameter int unsigned IN_W       = 16,
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned GAIN_W     = 4,
    parameter int unsigned LED_THRESH = 32'h0800,
    parameter int unsigned LED_HOLD   = 1000000
) (
    input  logic                         clk_sys,
    input  logic                         reset_n,
    input  logic                         ce_sample,
    input  logic [CHANNELS*IN_W-1:0]     ch_data,
    input  logic [CHANNELS-1:0]          ch_unsigned,
    input  logic [CHANNELS*GAIN_W-1:0]   ch_gain,
    input  logic                         mute,
    output logic [OUT_W-1:0]             audio_out,
    output logic                         out_valid,
    output logic                         clip,
    output logic                         level_led
);

    localparam int unsigned PW = IN_W + GAIN_W + 1;
    localparam int unsigned SW = PW + $clog2(CHANNELS);
    localparam int unsigned CW = $clog2(LED_HOLD + 1);
    localparam logic [CW-1:0]    HOLD_C = CW'(LED_HOLD);
    localparam logic [OUT_W-1:0] S_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] S_MIN  = {1'b1, {(OUT_W-1){1'b0}}};

    // ---------------- S1: conversion and gain ----------------
    logic signed [IN_W-1:0]   x_c    [CHANNELS];
    logic signed [GAIN_W:0]   g_c    [CHANNELS];
    logic signed [PW-1:0]     prod_c [CHANNELS];
    logic signed [PW-1:0]     p_q    [CHANNELS];
    logic                     v1_q;

    always_comb begin
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            // Offset-binary to two's complement is just an MSB flip.
            x_c[k]    = {ch_data[k*IN_W + IN_W - 1] ^ ch_unsigned[k],
                         ch_data[k*IN_W +: IN_W-1]};
            g_c[k]    = {1'b0, ch_gain[k*GAIN_W +: GAIN_W]};
            prod_c[k] = (PW'(x_c[k]) * PW'(g_c[k])) >>> GAIN_SHIFT;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            v1_q <= 1'b0;
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                p_q[k] <= '0;
            end
        end else begin
            v1_q <= ce_sample;
            if (ce_sample) begin
                for (int unsigned k = 0; k < CHANNELS; k++) begin
                    p_q[k] <= prod_c[k];
                end
            end
        end
    end

    // ---------------- S2: full-width sum ----------------
    logic signed [SW-1:0] sum_c;
    logic signed [SW-1:0] sum_q;
    logic                 v2_q;

    always_comb begin
        sum_c = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            sum_c = sum_c + SW'(p_q[k]);
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= '0;
            v2_q  <= 1'b0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                sum_q <= sum_c;
            end
        end
    end

    // ---------------- S3: saturate, attenuate, mute FSM ----------------
    logic signed [OUT_W-1:0] sat_c;
    logic                    clip_c;
    logic signed [OUT_W-1:0] att_out_c;
    logic [OUT_W-1:0]        mag_c;

    msx_audio_sat #(
        .IN_W  (SW),
        .OUT_W (OUT_W)
    ) u_sat (
        .din  (sum_q),
        .dout (sat_c),
        .clip (clip_c)
    );

    mute_state_t state_q, state_n;
    logic [3:0]  att_q, att_n;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= MUTED;
            att_q   <= ATT_MAX;
        end else begin
            state_q <= state_n;
            att_q   <= att_n;
        end
    end

    // The sample leaving S3 uses the current att; the FSM then steps, so a
    // reversal continues from the neighbouring level without repeating one.
    always_comb begin
        state_n = state_q;
        att_n   = att_q;
        if (v2_q) begin
            case (state_q)
                PLAY: begin
                    att_n = '0;
                    if (mute) begin
                        state_n = RAMP_DOWN;
                        att_n   = 4'd1;
                    end
                end
                RAMP_DOWN: begin
                    if (mute) begin
                        if (att_q >= ATT_MAX - 4'd1) begin
                            state_n = MUTED;
                            att_n   = ATT_MAX;
                        end else begin
                            att_n = att_q + 4'd1;
                        end
                    end else begin
                        att_n   = att_q - 4'd1;
                        state_n = (att_q <= 4'd1) ? PLAY : RAMP_UP;
                        if (att_q == '0) begin
                            att_n = '0;
                        end
                    end
                end
                MUTED: begin
                    att_n = ATT_MAX;
                    if (!mute) begin
                        state_n = RAMP_UP;
                    end
                end
                RAMP_UP: begin
                    if (mute) begin
                        if (att_q >= ATT_MAX - 4'd1) begin
                            state_n = MUTED;
                            att_n   = ATT_MAX;
                        end else begin
                            state_n = RAMP_DOWN;
                            att_n   = att_q + 4'd1;
                        end
                    end else begin
                        if (att_q <= 4'd1) begin
                            state_n = PLAY;
                            att_n   = '0;
                        end else begin
                            att_n = att_q - 4'd1;
                        end
                    end
                end
                default: begin
                    state_n = MUTED;
                    att_n   = ATT_MAX;
                end
            endcase
        end
    end

    always_comb begin
        att_out_c = (state_q == MUTED) ? '0 : (sat_c >>> att_q);
        // -max stands in for |min| so the magnitude never wraps.
        if (!att_out_c[OUT_W-1]) begin
            mag_c = att_out_c;
        end else if (att_out_c == S_MIN) begin
            mag_c = S_MAX;
        end else begin
            mag_c = -att_out_c;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            audio_out <= '0;
            out_valid <= 1'b0;
            clip      <= 1'b0;
        end else begin
            out_valid <= v2_q;
            clip      <= v2_q & clip_c;
            if (v2_q) begin
                audio_out <= att_out_c;
            end
        end
    end

    // ---------------- activity stretch ----------------
    // Counter starts at the ceiling so the LED stays dark until real activity.
    logic [CW-1:0] led_cnt_q, led_cnt_n;

    always_comb begin
        led_cnt_n = led_cnt_q;
        if (v2_q && (32'(mag_c) >= LED_THRESH)) begin
            led_cnt_n = '0;
        end else if (led_cnt_q < HOLD_C) begin
            led_cnt_n = led_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            led_cnt_q <= HOLD_C;
            level_led <= 1'b0;
        end else begin
            led_cnt_q <= led_cnt_n;
            level_led <= (led_cnt_n < HOLD_C);
        end
    end

endmodule

// File: tb/tb_msx_audio_mixer.sv
module tb_msx_audio_mixer;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ce_sample;
    logic [47:0] ch_data;
    logic [2:0]  ch_unsigned;
    logic [11:0] ch_gain;
    logic        mute;
    logic [15:0] audio_out;
    logic        out_valid;
    logic        clip;
    logic        level_led;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    always #5 clk_sys = ~clk_sys;

    msx_audio_mixer #(
        .CHANNELS   (3),
        .IN_W       (16),
        .OUT_W      (16),
        .GAIN_W     (4),
        .LED_THRESH (32'h0800),
        .LED_HOLD   (100)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ce_sample   (ce_sample),
        .ch_data     (ch_data),
        .ch_unsigned (ch_unsigned),
        .ch_gain     (ch_gain),
        .mute        (mute),
        .audio_out   (audio_out),
        .out_valid   (out_valid),
        .clip        (clip),
        .level_led   (level_led)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Strobe one sample, wait (bounded) for out_valid, return output/clip.
    task automatic run_sample(input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2,
                              output logic [15:0] o, output logic c);
        int unsigned lat;
        ch_data   = {c2, c1, c0};
        ce_sample = 1'b1;
        @(negedge clk_sys);
        ce_sample = 1'b0;
        lat = 1;
        while (!out_valid && lat < 6) begin
            @(negedge clk_sys);
            lat++;
        end
        check_eq("latency", lat, 3);
        o = audio_out;
        c = clip;
        @(negedge clk_sys);
    endtask

    always @(negedge clk_sys) begin
        if (clip) check_eq("clip_without_valid", {31'd0, out_valid}, 32'd1);
    end

    logic [15:0] o;
    logic        c;
    logic [15:0] exp_q[$];
    logic [15:0] d;
    int unsigned n_pulse, runs, hold;
    logic        prev;

    localparam logic [15:0] MUTE_EXP [11] = '{16'h4000, 16'h2000, 16'h1000, 16'h0800, 16'h0400,
                                              16'h0200, 16'h0400, 16'h0800, 16'h1000, 16'h2000,
                                              16'h4000};

    initial begin
        reset_n     = 1'b0;
        ce_sample   = 1'b0;
        ch_data     = '0;
        ch_unsigned = 3'b000;
        ch_gain     = {4'd8, 4'd8, 4'd8};
        mute        = 1'b0;
        repeat (3) @(negedge clk_sys);
        check_eq("rst_audio", {16'd0, audio_out}, 32'd0);
        check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_clip",  {31'd0, clip}, 32'd0);
        check_eq("rst_led",   {31'd0, level_led}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk_sys);

        // 1. power-up ramp-in
        run_sample(16'h4000, 16'h0, 16'h0, o, c);
        check_eq("ramp_muted", {16'd0, o}, 32'd0);
        for (int i = 2; i <= 16; i++) begin
            run_sample(16'h4000, 16'h0, 16'h0, o, c);
            check_eq("ramp_in", {16'd0, o}, {16'd0, 16'h4000 >> (17 - i)});
        end
        for (int i = 0; i < 2; i++) begin
            run_sample(16'h4000, 16'h0, 16'h0, o, c);
            check_eq("ramp_steady", {16'd0, o}, 32'h4000);
        end

        // 2. saturation
        run_sample(16'h7000, 16'h7000, 16'h7000, o, c);
        check_eq("sat_pos", {16'd0, o}, 32'h7FFF);
        check_eq("sat_pos_clip", {31'd0, c}, 32'd1);
        run_sample(16'h9000, 16'h9000, 16'h9000, o, c);
        check_eq("sat_neg", {16'd0, o}, 32'h8000);
        check_eq("sat_neg_clip", {31'd0, c}, 32'd1);
        run_sample(16'h7000, 16'h0, 16'h0, o, c);
        check_eq("no_sat", {16'd0, o}, 32'h7000);
        check_eq("no_sat_clip", {31'd0, c}, 32'd0);

        // 3. gain and conversion
        ch_gain = {4'd8, 4'd8, 4'd15};
        run_sample(16'h1000, 16'h0, 16'h0, o, c);
        check_eq("gain15", {16'd0, o}, 32'h1E00);
        ch_gain = {4'd8, 4'd8, 4'd0};
        run_sample(16'h1000, 16'h0, 16'h0, o, c);
        check_eq("gain0", {16'd0, o}, 32'h0);
        ch_gain     = {4'd8, 4'd8, 4'd8};
        ch_unsigned = 3'b010;
        run_sample(16'h0, 16'h8000, 16'h0, o, c);
        check_eq("uns_mid", {16'd0, o}, 32'h0);
        run_sample(16'h0, 16'h0000, 16'h0, o, c);
        check_eq("uns_zero", {16'd0, o}, 32'h8000);
        check_eq("uns_zero_clip", {31'd0, c}, 32'd0);
        ch_unsigned = 3'b000;

        // 4. mute reversal: 5 muted samples then release
        for (int i = 0; i < 11; i++) begin
            mute = (i < 5);
            run_sample(16'h4000, 16'h0, 16'h0, o, c);
            check_eq("mute_rev", {16'd0, o}, {16'd0, MUTE_EXP[i]});
        end
        mute = 1'b0;

        // 6. level LED stretch (before the reset test leaves the mixer muted)
        repeat (120) @(negedge clk_sys);
        check_eq("led_idle", {31'd0, level_led}, 32'd0);
        run_sample(16'h0900, 16'h0, 16'h0, o, c);
        // run_sample returns one clock after the out_valid cycle
        hold = 1;
        while (level_led && hold < 200) begin
            @(negedge clk_sys);
            hold++;
        end
        check_eq("led_hold", hold, 100);
        run_sample(16'h07FF, 16'h0, 16'h0, o, c);
        check_eq("led_below", {31'd0, level_led}, 32'd0);
        run_sample(16'hF800, 16'h0, 16'h0, o, c);
        check_eq("led_neg_thresh", {31'd0, level_led}, 32'd1);

        // 5a. back-to-back strobes
        n_pulse = 0;
        runs    = 0;
        prev    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i < 10) begin
                d = 16'((i + 1) * 256);
                ch_data = {32'd0, d};
                exp_q.push_back(d);
                ce_sample = 1'b1;
            end else begin
                ce_sample = 1'b0;
            end
            @(negedge clk_sys);
            if (out_valid) begin
                n_pulse++;
                if (!prev) runs++;
                if (exp_q.size() > 0) check_eq("b2b_data", {16'd0, audio_out}, {16'd0, exp_q.pop_front()});
            end
            prev = out_valid;
        end
        check_eq("b2b_count", n_pulse, 10);
        check_eq("b2b_runs", runs, 1);

        // 5b. reset at the 5th clock of a strobe burst
        ch_data   = {32'd0, 16'h1000};
        ce_sample = 1'b1;
        repeat (4) @(negedge clk_sys);
        reset_n   = 1'b0;
        ce_sample = 1'b0;
        #1;
        check_eq("mid_rst_audio", {16'd0, audio_out}, 32'd0);
        check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mid_rst_led", {31'd0, level_led}, 32'd0);
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        n_pulse = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_sys);
            if (out_valid) n_pulse++;
        end
        check_eq("mid_rst_no_valid", n_pulse, 0);
        run_sample(16'h4000, 16'h0, 16'h0, o, c);
        check_eq("post_rst_muted", {16'd0, o}, 32'd0);
        run_sample(16'h4000, 16'h0, 16'h0, o, c);
        check_eq("post_rst_att15", {16'd0, o}, 32'd0);
        run_sample(16'h4000, 16'h0, 16'h0, o, c);
        check_eq("post_rst_att14", {16'd0, o}, 32'd1);
        run_sample(16'h4000, 16'h0, 16'h0, o, c);
        check_eq("post_rst_att13", {16'd0, o}, 32'd2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
